// File: rtl/seq_divider_hs.sv
// seq_divider_hs: multi-cycle non-restoring divider with valid/ready handshakes; signed mode built when DIV_SIGNED_EN is defined
module seq_divider_hs #(
  parameter int WIDTH = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             signed_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow,
  output logic             busy
);
  localparam int N = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, OUT} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] q, b, q_step, r_fix, q_fix, rem_fix;
  logic [WIDTH:0] r, r_step;
  logic [CW-1:0] cnt;
  logic sgn, sop, q_neg, r_neg, fire_in, dz, ov;
`ifdef DIV_SIGNED_EN
  assign sgn = signed_op;
`else
  logic unused_sop;
  assign unused_sop = signed_op;
  assign sgn = 1'b0;
`endif
  assign in_ready = state == IDLE;
  assign busy = state != IDLE;
  assign out_valid = state == OUT;
  assign fire_in = in_valid && in_ready;
  assign dz = divisor == '0;
  assign ov = sgn && dividend == MIN && divisor == '1;
  // r stays in [-b, b) between steps, so wrap-around in the shifted value is harmless
  always_comb begin
    r_step = r;
    q_step = q;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      r_step = r_step[WIDTH] ? {r_step[WIDTH-1:0], q_step[WIDTH-1]} + {1'b0, b}
                             : {r_step[WIDTH-1:0], q_step[WIDTH-1]} - {1'b0, b};
      q_step = {q_step[WIDTH-2:0], ~r_step[WIDTH]};
    end
  end
  assign r_fix = r[WIDTH-1:0] + (r[WIDTH] ? b : '0);
  assign rem_fix = r_neg ? -r_fix : r_fix;
  assign q_fix = q_neg ? -q : q;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = fire_in ? ((dz || ov) ? OUT : PREP) : IDLE;
      PREP: state_n = ITER;
      ITER: state_n = cnt == CW'(1) ? FIX : ITER;
      FIX:  state_n = OUT;
      OUT:  state_n = out_ready ? IDLE : OUT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (fire_in) begin
          q <= dividend;
          b <= divisor;
          sop <= sgn;
          div_by_zero <= dz;
          overflow <= ov;
          if (dz || ov) begin
            quotient <= dz ? '1 : MIN;
            remainder <= dz ? dividend : '0;
          end
        end
        PREP: begin
          q <= (sop && q[WIDTH-1]) ? -q : q;
          b <= (sop && b[WIDTH-1]) ? -b : b;
          r <= '0;
          cnt <= CW'(N);
          q_neg <= sop && (q[WIDTH-1] ^ b[WIDTH-1]);
          r_neg <= sop && q[WIDTH-1];
        end
        ITER: begin
          r <= r_step;
          q <= q_step;
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          quotient <= q_fix;
          remainder <= rem_fix;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider_hs.sv
// tb_seq_divider_hs: directed checks of results, flags, latency, back-pressure and reset for seq_divider_hs
module tb_seq_divider_hs;
  localparam int W = 8;
  localparam int BPC = 1;
  localparam int LAT = W / BPC + 2;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0, signed_op = 0;
  logic [W-1:0] dividend = 0, divisor = 0;
  logic in_ready, out_valid, div_by_zero, overflow, busy;
  logic [W-1:0] quotient, remainder;
  int total = 0, bad = 0;

  seq_divider_hs #(.WIDTH(W), .BITS_PER_CYCLE(BPC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .signed_op(signed_op),
    .out_valid(out_valid), .out_ready(out_ready), .quotient(quotient),
    .remainder(remainder), .div_by_zero(div_by_zero), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic start(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    dividend = x;
    divisor = y;
    signed_op = s;
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    dividend = 0;
    divisor = 0;
    signed_op = 0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take();
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    total++;
    if ({out_valid, in_ready, busy, quotient, remainder, div_by_zero, overflow} !== {1'b0, 1'b1, 1'b0, 16'h0, 2'b00}) begin
      bad++;
      $display("FAIL reset: got v=%b rdy=%b busy=%b q=%h r=%h z=%b o=%b, want 0 1 0 00 00 0 0",
               out_valid, in_ready, busy, quotient, remainder, div_by_zero, overflow);
    end
  endtask

  task automatic test_unsigned();
    logic [4*W-1:0] vec [5] = '{{8'd100, 8'd7, 8'd14, 8'd2}, {8'd255, 8'd1, 8'd255, 8'd0},
                                {8'd13, 8'd13, 8'd1, 8'd0}, {8'd5, 8'd200, 8'd0, 8'd5},
                                {8'd255, 8'd16, 8'd15, 8'd15}};
    int lat;
    for (int i = 0; i < 5; i++) begin
      start(vec[i][31:24], vec[i][23:16], 1'b0);
      wait_out(lat);
      total++;
      if (lat !== LAT) begin
        bad++;
        $display("FAIL unsigned_latency[%0d]: got %0d edges, want %0d", i, lat, LAT);
      end
      total++;
      if ({quotient, remainder, div_by_zero, overflow} !== {vec[i][15:0], 2'b00}) begin
        bad++;
        $display("FAIL unsigned[%0d]: got q=%h r=%h z=%b o=%b, want q=%h r=%h z=0 o=0",
                 i, quotient, remainder, div_by_zero, overflow, vec[i][15:8], vec[i][7:0]);
      end
      take();
    end
  endtask

  task automatic test_div_zero();
    int lat;
    start(8'd55, 8'd0, 1'b0);
    wait_out(lat);
    total++;
    if ({lat[7:0], quotient, remainder, div_by_zero, overflow, busy} !== {8'd0, 8'hFF, 8'd55, 3'b101}) begin
      bad++;
      $display("FAIL div_zero: got lat=%0d q=%h r=%h z=%b o=%b busy=%b, want lat=0 q=ff r=37 z=1 o=0 busy=1",
               lat, quotient, remainder, div_by_zero, overflow, busy);
    end
    take();
  endtask

  task automatic test_overflow();
    int lat;
    logic [W+W+2+7:0] want;
`ifdef DIV_SIGNED_EN
    want = {8'd0, 8'h80, 8'h00, 2'b01};
`else
    want = {LAT[7:0], 8'h00, 8'h80, 2'b00};
`endif
    start(8'h80, 8'hFF, 1'b1);
    wait_out(lat);
    total++;
    if ({lat[7:0], quotient, remainder, div_by_zero, overflow} !== want) begin
      bad++;
      $display("FAIL overflow: got lat=%0d q=%h r=%h z=%b o=%b, want lat=%0d q=%h r=%h z=%b o=%b",
               lat, quotient, remainder, div_by_zero, overflow, want[25:18], want[17:10], want[9:2], want[1], want[0]);
    end
    take();
  endtask

  task automatic test_signed();
    int lat;
    logic [4*W:0] vec [3];
`ifdef DIV_SIGNED_EN
    vec = '{{1'b1, 8'hF9, 8'h02, 8'hFD, 8'hFF}, {1'b1, 8'h07, 8'hFE, 8'hFD, 8'h01},
            {1'b0, 8'h80, 8'hFF, 8'h00, 8'h80}};
`else
    vec = '{{1'b1, 8'hF9, 8'h02, 8'h7C, 8'h01}, {1'b1, 8'h07, 8'hFE, 8'h00, 8'h07},
            {1'b0, 8'h80, 8'hFF, 8'h00, 8'h80}};
`endif
    for (int i = 0; i < 3; i++) begin
      start(vec[i][31:24], vec[i][23:16], vec[i][32]);
      wait_out(lat);
      total++;
      if ({lat[7:0], quotient, remainder, div_by_zero, overflow} !== {LAT[7:0], vec[i][15:0], 2'b00}) begin
        bad++;
        $display("FAIL signed[%0d]: got lat=%0d q=%h r=%h z=%b o=%b, want lat=%0d q=%h r=%h z=0 o=0",
                 i, lat, quotient, remainder, div_by_zero, overflow, LAT, vec[i][15:8], vec[i][7:0]);
      end
      take();
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    start(8'd100, 8'd7, 1'b0);
    wait_out(lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if ({out_valid, in_ready, quotient, remainder} !== {2'b10, 8'd14, 8'd2}) begin
        bad++;
        $display("FAIL stall[%0d]: got v=%b rdy=%b q=%h r=%h, want v=1 rdy=0 q=0e r=02",
                 i, out_valid, in_ready, quotient, remainder);
      end
    end
    dividend = 8'd13;
    divisor = 8'd13;
    in_valid = 1;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL handshake_edge: got v=%b rdy=%b, want v=0 rdy=1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 0;
    total++;
    if ({in_ready, busy} !== 2'b01) begin
      bad++;
      $display("FAIL next_accept: got rdy=%b busy=%b, want rdy=0 busy=1", in_ready, busy);
    end
    wait_out(lat);
    total++;
    if ({lat[7:0], quotient, remainder} !== {LAT[7:0], 8'd1, 8'd0}) begin
      bad++;
      $display("FAIL back_to_back: got lat=%0d q=%h r=%h, want lat=%0d q=01 r=00", lat, quotient, remainder, LAT);
    end
    take();
  endtask

  task automatic test_reset_iter();
    int lat;
    start(8'd255, 8'd16, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
    rst = 0;
    total++;
    if ({out_valid, in_ready, busy, quotient, remainder, div_by_zero, overflow} !== {1'b0, 1'b1, 1'b0, 16'h0, 2'b00}) begin
      bad++;
      $display("FAIL reset_iter: got v=%b rdy=%b busy=%b q=%h r=%h z=%b o=%b, want 0 1 0 00 00 0 0",
               out_valid, in_ready, busy, quotient, remainder, div_by_zero, overflow);
    end
    start(8'd200, 8'd9, 1'b0);
    wait_out(lat);
    total++;
    if ({lat[7:0], quotient, remainder, div_by_zero, overflow} !== {LAT[7:0], 8'd22, 8'd2, 2'b00}) begin
      bad++;
      $display("FAIL after_reset: got lat=%0d q=%h r=%h z=%b o=%b, want lat=%0d q=16 r=02 z=0 o=0",
               lat, quotient, remainder, div_by_zero, overflow, LAT);
    end
    take();
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_div_zero();
    test_overflow();
    test_signed();
    test_back_to_back();
    test_reset_iter();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
